rram_program_sequencer: RTL and testbench

- Sits directly upstream of the RRAM crossbar controller and drives its INSTR/OPCODE/DATAIN/valid interface.
- Turns one host "program row" request into the full instruction stream:
  - 8 WRITE_WEIGHTS beats.
  - Optional 8 WRITE_COLSEL beats.
  - A PROGRAM_DEVICE pulse held for a counted number of cycles.
  - A NO_OP gap.
  - A completion token back to the host.
- Also serves single-beat RESET_REGS requests.

---
 rtl/rram_pkg.sv | 61 ++++++
 rtl/rram_pulse_timer.sv | 42 ++++
 rtl/rram_program_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_rram_program_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rram_pkg.sv
// Shared definitions for the RRAM program sequencer: controller instruction codes,
// host request/state encodings, latched request record and opcode builders.
package rram_pkg;

  localparam int NUM_SL       = 512;
  localparam int DATAIN_WIDTH = 64;
  localparam int NUM_WORDS    = NUM_SL / DATAIN_WIDTH;
  localparam int INSTR_WIDTH  = 4;
  localparam int OPCODE_WIDTH = 18;
  localparam int IDX_W        = $clog2(NUM_WORDS);
  localparam int PULSE_W      = 8;

  localparam logic [INSTR_WIDTH-1:0] INSTR_NO_OP          = 4'd0;
  localparam logic [INSTR_WIDTH-1:0] INSTR_WRITE_WEIGHTS  = 4'd1;
  localparam logic [INSTR_WIDTH-1:0] INSTR_WRITE_COLSEL   = 4'd2;
  localparam logic [INSTR_WIDTH-1:0] INSTR_PROGRAM_DEVICE = 4'd3;
  localparam logic [INSTR_WIDTH-1:0] INSTR_RESET_REGS     = 4'd9;

  typedef enum logic [1:0] {
    OP_RSVD0       = 2'd0,
    OP_PROGRAM_ROW = 2'd1,
    OP_RESET_REGS  = 2'd2,
    OP_RSVD3       = 2'd3
  } req_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_CS,
    S_PULSE,
    S_GAP,
    S_RST_BEAT,
    S_DONE
  } state_e;

  // Request fields still needed after the accept cycle; op is consumed by the branch.
  typedef struct packed {
    logic [9:0]         row;
    logic [PULSE_W-1:0] pulse;
    logic               row_pol;
    logic               col_pol;
    logic               colsel_all;
  } req_fields_t;

  function automatic logic [OPCODE_WIDTH-1:0] program_opcode(
    input logic       row_pol,
    input logic       col_pol,
    input logic [9:0] row
  );
    return {6'b0, row_pol, col_pol, row};
  endfunction

  // Word index travels in OPCODE[8:6]; everything else stays zero.
  function automatic logic [OPCODE_WIDTH-1:0] index_opcode(input logic [IDX_W-1:0] idx);
    logic [OPCODE_WIDTH-1:0] opc;
    opc = '0;
    opc[6 +: IDX_W] = idx;
    return opc;
  endfunction

endpackage

// File: rtl/rram_pulse_timer.sv
// Counts the held cycles of a PROGRAM_DEVICE pulse after its accepted first cycle.
// last marks the final held cycle; the count never wraps below zero.
module rram_pulse_timer
  import rram_pkg::*;
(
  input  logic               CLK,
  input  logic               RSTb,
  input  logic               load,
  input  logic [PULSE_W-1:0] load_val,
  output logic               active,
  output logic               last
);

  logic [PULSE_W-1:0] count_reg, count_next;
  logic               active_reg, active_next;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      count_reg  <= '0;
      active_reg <= 1'b0;
    end else begin
      count_reg  <= count_next;
      active_reg <= active_next;
    end
  end

  always_comb begin
    count_next  = count_reg;
    active_next = active_reg;
    if (load) begin
      count_next  = load_val;
      active_next = (load_val != '0);
    end else if (active_reg && (count_reg != '0)) begin
      count_next = count_reg - 1'b1;
      if (count_reg == PULSE_W'(1)) active_next = 1'b0;
    end
  end

  assign active = active_reg;
  assign last   = active_reg && (count_reg == PULSE_W'(1));

endmodule

// File: rtl/rram_program_sequencer.sv
// Expands one host request into the crossbar controller instruction stream:
// weight beats, optional column-select beats, a timed program pulse, a gap and a done token.
module rram_program_sequencer
  import rram_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_op,
  input  logic [9:0]              req_row,
  input  logic [PULSE_W-1:0]      req_pulse,
  input  logic                    req_row_pol,
  input  logic                    req_col_pol,
  input  logic                    req_colsel_all,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  input  logic [DATAIN_WIDTH-1:0] wdata,
  output logic [INSTR_WIDTH-1:0]  INSTR,
  output logic [OPCODE_WIDTH-1:0] OPCODE,
  output logic [DATAIN_WIDTH-1:0] DATAIN,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    done_valid,
  input  logic                    done_ready,
  output logic                    done_err,
  output logic                    busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_e             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  req_fields_t        req_reg, req_next;
  logic               err_reg, err_next;
  logic               idle_ready;
  logic               timer_load;
  logic [PULSE_W-1:0] timer_val;
  logic               timer_active;
  logic               timer_last;

  rram_pulse_timer u_pulse_timer (
    .CLK      (CLK),
    .RSTb     (RSTb),
    .load     (timer_load),
    .load_val (timer_val),
    .active   (timer_active),
    .last     (timer_last)
  );

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      req_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      req_reg   <= req_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    req_next    = req_reg;
    err_next    = err_reg;
    timer_load  = 1'b0;
    timer_val   = '0;
    idle_ready  = 1'b0;
    wdata_ready = 1'b0;
    INSTR       = INSTR_NO_OP;
    OPCODE      = '0;
    DATAIN      = '0;
    valid_o     = 1'b0;
    done_valid  = 1'b0;
    done_err    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        idle_ready = 1'b1;
        if (req_valid) begin
          req_next.row        = req_row;
          req_next.pulse      = req_pulse;
          req_next.row_pol    = req_row_pol;
          req_next.col_pol    = req_col_pol;
          req_next.colsel_all = req_colsel_all;
          idx_next            = '0;
          err_next            = 1'b0;
          case (req_op_e'(req_op))
            OP_PROGRAM_ROW: begin
              if (req_pulse != '0) begin
                state_next = S_LOAD_W;
              end else begin
                state_next = S_DONE;
                err_next   = 1'b1;
              end
            end
            OP_RESET_REGS: state_next = S_RST_BEAT;
            default: begin
              state_next = S_DONE;
              err_next   = 1'b1;
            end
          endcase
        end
      end

      // Weight words pass straight through; a host stall simply drops valid_o.
      S_LOAD_W: begin
        valid_o     = wdata_valid;
        INSTR       = wdata_valid ? INSTR_WRITE_WEIGHTS : INSTR_NO_OP;
        DATAIN      = wdata;
        OPCODE      = index_opcode(idx_reg);
        wdata_ready = ready_i;
        if (wdata_valid && ready_i) begin
          if (idx_reg == LAST_IDX) begin
            idx_next   = '0;
            state_next = req_reg.colsel_all ? S_LOAD_CS : S_PULSE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end

      S_LOAD_CS: begin
        valid_o = 1'b1;
        INSTR   = INSTR_WRITE_COLSEL;
        OPCODE  = index_opcode(idx_reg);
        if (ready_i) begin
          if (idx_reg == LAST_IDX) begin
            idx_next   = '0;
            state_next = S_PULSE;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end

      // The accepted cycle is pulse cycle 1; the timer covers the remaining pulse-1.
      S_PULSE: begin
        valid_o = 1'b1;
        INSTR   = INSTR_PROGRAM_DEVICE;
        OPCODE  = program_opcode(req_reg.row_pol, req_reg.col_pol, req_reg.row);
        if (!timer_active) begin
          if (ready_i) begin
            timer_load = 1'b1;
            timer_val  = req_reg.pulse - 1'b1;
            if (req_reg.pulse == PULSE_W'(1)) state_next = S_GAP;
          end
        end else if (timer_last) begin
          state_next = S_GAP;
        end
      end

      S_GAP: begin
        state_next = S_DONE;
        err_next   = 1'b0;
      end

      S_RST_BEAT: begin
        valid_o = 1'b1;
        INSTR   = INSTR_RESET_REGS;
        if (ready_i) begin
          state_next = S_DONE;
          err_next   = 1'b0;
        end
      end

      S_DONE: begin
        done_valid = 1'b1;
        done_err   = err_reg;
        if (done_ready) state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  // Hold off requests while reset is asserted even though the state reads IDLE.
  assign req_ready = idle_ready && RSTb;
  assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_rram_program_sequencer.sv
// Bench for rram_program_sequencer: directed vector table plus randomized requests,
// checked against a beat-list model built from the request fields.
module tb_rram_program_sequencer;
  import rram_pkg::*;

  logic                    CLK = 1'b0;
  logic                    RSTb = 1'b0;
  logic                    req_valid = 1'b0;
  logic                    req_ready;
  logic [1:0]              req_op = '0;
  logic [9:0]              req_row = '0;
  logic [7:0]              req_pulse = '0;
  logic                    req_row_pol = 1'b0;
  logic                    req_col_pol = 1'b0;
  logic                    req_colsel_all = 1'b0;
  logic                    wdata_valid = 1'b0;
  logic                    wdata_ready;
  logic [63:0]             wdata = '0;
  logic [3:0]              INSTR;
  logic [17:0]             OPCODE;
  logic [63:0]             DATAIN;
  logic                    valid_o;
  logic                    ready_i = 1'b0;
  logic                    done_valid;
  logic                    done_ready = 1'b0;
  logic                    done_err;
  logic                    busy;

  always #5 CLK = ~CLK;

  rram_program_sequencer dut (
    .CLK            (CLK),
    .RSTb           (RSTb),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_row        (req_row),
    .req_pulse      (req_pulse),
    .req_row_pol    (req_row_pol),
    .req_col_pol    (req_col_pol),
    .req_colsel_all (req_colsel_all),
    .wdata_valid    (wdata_valid),
    .wdata_ready    (wdata_ready),
    .wdata          (wdata),
    .INSTR          (INSTR),
    .OPCODE         (OPCODE),
    .DATAIN         (DATAIN),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .done_valid     (done_valid),
    .done_ready     (done_ready),
    .done_err       (done_err),
    .busy           (busy)
  );

  typedef struct {
    logic [1:0] op;
    logic [9:0] row;
    logic [7:0] pulse;
    logic       rp;
    logic       cp;
    logic       cs;
    int         ready_mode;   // 0: always ready, 1: toggling, 2: random
    int         stall_after;  // word index after which wdata_valid drops 3 cycles, -1 none
    int         rst_pcycle;   // pulse cycle in which RSTb is asserted, 0 none
    int         done_hold;    // cycles to hold done_ready low with a new request pending
    int         exp_nbeats;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [3:0]  instr;
    logic [17:0] opc;
    logic [63:0] data;
    bit          cmp_data;
  } beat_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Expected totals derived from the request rules alone.
  function automatic vec_t fill_exp(input vec_t v);
    vec_t r;
    r = v;
    if (v.op == 2'd1 && v.pulse != 8'd0) begin
      r.exp_nbeats = NUM_WORDS + (v.cs ? NUM_WORDS : 0) + 1;
      r.exp_err    = 1'b0;
    end else if (v.op == 2'd2) begin
      r.exp_nbeats = 1;
      r.exp_err    = 1'b0;
    end else begin
      r.exp_nbeats = 0;
      r.exp_err    = 1'b1;
    end
    return r;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    beat_t exp_q[$];
    beat_t got_q[$];
    beat_t b;
    logic [63:0] w [NUM_WORDS];
    int wptr = 0;
    int cyc = 0;
    int pcount = 0;
    int gap = 0;
    int stall = 0;
    int hold_left;
    bit prog;
    bit req_done = 0;
    bit pstarted = 0;
    bit finished = 0;
    bit aborted = 0;
    bit wv_hold = 0;
    bit in_stall = 0;
    bit err_seen = 0;
    bit prev_hold = 0;
    logic [3:0]  prev_instr = '0;
    logic [17:0] prev_opc = '0;

    prog      = (v.op == 2'd1) && (v.pulse != 8'd0);
    hold_left = v.done_hold;
    for (int i = 0; i < NUM_WORDS; i++) w[i] = {$urandom(), $urandom()};

    if (prog) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        b.instr = 4'd1; b.opc = 18'(i) << 6; b.data = w[i]; b.cmp_data = 1;
        exp_q.push_back(b);
      end
      if (v.cs) begin
        for (int i = 0; i < NUM_WORDS; i++) begin
          b.instr = 4'd2; b.opc = 18'(i) << 6; b.data = 64'd0; b.cmp_data = 1;
          exp_q.push_back(b);
        end
      end
      b.instr = 4'd3; b.opc = {6'd0, v.rp, v.cp, v.row}; b.data = 64'd0; b.cmp_data = 0;
      exp_q.push_back(b);
    end else if (v.op == 2'd2) begin
      b.instr = 4'd9; b.opc = 18'd0; b.data = 64'd0; b.cmp_data = 0;
      exp_q.push_back(b);
    end

    while (!finished && cyc < 4000) begin
      if (!req_done) begin
        req_valid = 1'b1; req_op = v.op; req_row = v.row; req_pulse = v.pulse;
        req_row_pol = v.rp; req_col_pol = v.cp; req_colsel_all = v.cs;
      end else if (hold_left > 0) begin
        req_valid = 1'b1; req_op = 2'd2; req_pulse = 8'd0;
      end else begin
        req_valid = 1'b0;
      end
      case (v.ready_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = (cyc % 2 == 0);
        default: ready_i = ($urandom % 3 != 0);
      endcase
      in_stall = 0;
      if (stall > 0) begin
        wdata_valid = 1'b0; in_stall = 1; stall--;
      end else if (prog && wptr < NUM_WORDS) begin
        wdata_valid = (v.ready_mode != 2) || wv_hold || ($urandom % 4 != 0);
      end else begin
        wdata_valid = 1'b0;
      end
      if (prog && wptr < NUM_WORDS) wdata = w[wptr];
      else wdata = 64'd0;
      if (v.done_hold > 0) done_ready = (hold_left == 0);
      else done_ready = ($urandom % 2 == 0);

      @(negedge CLK);
      if (prev_hold) begin
        chk("stall_hold_valid", valid_o, 1);
        chk("stall_hold_instr", INSTR, prev_instr);
        chk("stall_hold_opcode", OPCODE, prev_opc);
      end
      if (in_stall) begin
        chk("wstall_valid", valid_o, 0);
        chk("wstall_instr", INSTR, 0);
        chk("wstall_index", OPCODE[8:6], v.stall_after + 1);
      end
      if (valid_o && INSTR == 4'd3) begin
        if (pstarted) pcount++;
        else if (ready_i) begin
          pstarted = 1; pcount = 1;
          b.instr = INSTR; b.opc = OPCODE; b.data = DATAIN; b.cmp_data = 0;
          got_q.push_back(b);
        end
      end else begin
        if (valid_o && ready_i) begin
          b.instr = INSTR; b.opc = OPCODE; b.data = DATAIN; b.cmp_data = 0;
          got_q.push_back(b);
        end
        if (pstarted && !done_valid) begin
          gap++;
          chk("gap_valid", valid_o, 0);
          chk("gap_instr", INSTR, 0);
        end
      end
      if (req_valid && req_ready) begin
        if (req_done) chk("early_accept", 1, 0);
        req_done = 1;
      end
      if (wdata_valid && wdata_ready) begin
        wptr++; wv_hold = 0;
        if (v.stall_after >= 0 && wptr == v.stall_after + 1) stall = 3;
      end else begin
        wv_hold = wdata_valid;
      end
      prev_hold  = valid_o && !ready_i && !(INSTR == 4'd3 && pstarted);
      prev_instr = INSTR;
      prev_opc   = OPCODE;
      if (done_valid) begin
        if (!err_seen) begin
          chk("done_err", done_err, v.exp_err);
          chk("busy_at_done", busy, 1);
          err_seen = 1;
        end
        if (hold_left > 0) begin
          chk("hold_req_ready", req_ready, 0);
          hold_left--;
        end
        if (done_ready) finished = 1;
      end

      if (v.rst_pcycle > 0 && pstarted && pcount == v.rst_pcycle) begin
        #1 RSTb = 1'b0;
        #1;
        chk("rst_instr", INSTR, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);
        @(posedge CLK);
        #1 RSTb = 1'b1;
        req_valid = 1'b0; wdata_valid = 1'b0; done_ready = 1'b1;
        repeat (3) begin
          @(negedge CLK);
          chk("post_rst_busy", busy, 0);
          chk("post_rst_req_ready", req_ready, 1);
          chk("post_rst_done", done_valid, 0);
          @(posedge CLK);
          #1;
        end
        aborted = 1;
        finished = 1;
      end else begin
        @(posedge CLK);
        #1;
      end
      cyc++;
    end

    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL timeout txn %0d: no done token after %0d cycles", id, cyc);
    end else if (!aborted) begin
      chk("nbeats_table", got_q.size(), v.exp_nbeats);
      chk("nbeats_model", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        chk("beat_instr", got_q[i].instr, exp_q[i].instr);
        chk("beat_opcode", got_q[i].opc, exp_q[i].opc);
        if (exp_q[i].cmp_data) chk("beat_data", got_q[i].data, exp_q[i].data);
      end
      if (prog) begin
        chk("pulse_cycles", pcount, v.pulse);
        chk("gap_cycles", gap, 1);
      end
    end
    req_valid = 1'b0; wdata_valid = 1'b0; done_ready = 1'b0;
    $display("txn %0d op=%0d row=%0d pulse=%0d cs=%0d beats=%0d pulse_cycles=%0d cycles=%0d%s",
             id, v.op, v.row, v.pulse, v.cs, got_q.size(), pcount, cyc, aborted ? " aborted" : "");
  endtask

  initial begin
    vecs[0]  = '{2'd1, 10'd37,   8'd4,   1'b1, 1'b0, 1'b0, 0, -1, 0, 0, 9,  1'b0};
    vecs[1]  = '{2'd1, 10'd1023, 8'd2,   1'b0, 1'b1, 1'b1, 1, -1, 0, 0, 17, 1'b0};
    vecs[2]  = '{2'd1, 10'd5,    8'd1,   1'b0, 1'b0, 1'b0, 0,  2, 0, 0, 9,  1'b0};
    vecs[3]  = '{2'd1, 10'd9,    8'd0,   1'b1, 1'b1, 1'b1, 0, -1, 0, 0, 0,  1'b1};
    vecs[4]  = '{2'd0, 10'd9,    8'd5,   1'b0, 1'b0, 1'b0, 0, -1, 0, 0, 0,  1'b1};
    vecs[5]  = '{2'd3, 10'd9,    8'd5,   1'b0, 1'b0, 1'b0, 2, -1, 0, 0, 0,  1'b1};
    vecs[6]  = '{2'd2, 10'd0,    8'd0,   1'b0, 1'b0, 1'b0, 0, -1, 0, 5, 1,  1'b0};
    vecs[7]  = '{2'd2, 10'd3,    8'd7,   1'b1, 1'b0, 1'b0, 2, -1, 0, 0, 1,  1'b0};
    vecs[8]  = '{2'd1, 10'd100,  8'd8,   1'b1, 1'b1, 1'b0, 0, -1, 2, 0, 9,  1'b0};
    vecs[9]  = '{2'd1, 10'd512,  8'd255, 1'b0, 1'b1, 1'b1, 2, -1, 0, 0, 17, 1'b0};
    vecs[10] = '{2'd1, 10'd700,  8'd3,   1'b1, 1'b1, 1'b1, 2, -1, 0, 0, 17, 1'b0};

    RSTb = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_instr", INSTR, 0);
    chk("reset_opcode", OPCODE, 0);
    chk("reset_datain", DATAIN, 0);
    chk("reset_valid", valid_o, 0);
    chk("reset_wdata_ready", wdata_ready, 0);
    chk("reset_done_valid", done_valid, 0);
    chk("reset_done_err", done_err, 0);
    chk("reset_busy", busy, 0);
    chk("reset_req_ready", req_ready, 0);
    RSTb = 1'b1;
    @(negedge CLK);
    chk("idle_req_ready", req_ready, 1);
    chk("idle_busy", busy, 0);
    @(posedge CLK);
    #1;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    for (int t = 0; t < 25; t++) begin
      vec_t r;
      int k;
      k = int'($urandom % 8);
      r.op          = (k < 5) ? 2'd1 : (k == 5) ? 2'd2 : (k == 6) ? 2'd0 : 2'd3;
      r.row         = 10'($urandom);
      r.pulse       = ($urandom % 6 == 0) ? 8'd0 : 8'(1 + $urandom % 12);
      r.rp          = 1'($urandom);
      r.cp          = 1'($urandom);
      r.cs          = 1'($urandom);
      r.ready_mode  = 2;
      r.stall_after = -1;
      r.rst_pcycle  = 0;
      r.done_hold   = 0;
      r.exp_nbeats  = 0;
      r.exp_err     = 1'b0;
      r = fill_exp(r);
      run_vec(100 + t, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
